// File: rtl/pe_matrix_expectation_seq_pkg.sv
// Shared widths, state encoding and the widening multiply used by every
// sigma-point expectation lane.
package pe_matrix_expectation_seq_pkg;

    localparam int SIGMA_W  = 32;
    localparam int WEIGHT_W = 32;
    localparam int ACC_W    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Signed 32x32 multiply producing the low 64 bits of the product.
    // Both operands are sign-extended to the accumulator width first, so the
    // low 64 bits equal the true signed product and the later add wraps
    // naturally modulo 2^64.
    function automatic logic [ACC_W-1:0] mul_wide(
        input logic [WEIGHT_W-1:0] a,
        input logic [SIGMA_W-1:0]  b
    );
        logic [ACC_W-1:0] a_ext;
        logic [ACC_W-1:0] b_ext;
        a_ext = {{(ACC_W-WEIGHT_W){a[WEIGHT_W-1]}}, a};
        b_ext = {{(ACC_W-SIGMA_W){b[SIGMA_W-1]}}, b};
        return a_ext * b_ext;
    endfunction

endpackage

// File: rtl/pe_matrix_expectation_seq_if.sv
// Stream interface of the expectation sequencer: pair input, mean output,
// control pulse and status.
interface pe_matrix_expectation_seq_if #(
    parameter int DIM_SIGMA = 5
);
    import pe_matrix_expectation_seq_pkg::*;

    logic                          start;
    logic                          in_valid;
    logic                          in_ready;
    logic [WEIGHT_W-1:0]           weight;
    logic [SIGMA_W*DIM_SIGMA-1:0]  sigma;
    logic                          out_valid;
    logic                          out_ready;
    logic [ACC_W*DIM_SIGMA-1:0]    mean;
    logic                          busy;

    modport master (
        output start, in_valid, weight, sigma, out_ready,
        input  in_ready, out_valid, mean, busy
    );

    modport slave (
        input  start, in_valid, weight, sigma, out_ready,
        output in_ready, out_valid, mean, busy
    );

endinterface

// File: rtl/pe_matrix_expectation_comb.sv
// Combinational MAC array: each lane computes D = C + A*B with a 32x32
// signed product and a wrapping 64-bit add.
module pe_matrix_expectation_comb
    import pe_matrix_expectation_seq_pkg::*;
#(
    parameter int DIM_SIGMA = 5
) (
    input  logic [WEIGHT_W-1:0]          a,
    input  logic [SIGMA_W*DIM_SIGMA-1:0] b,
    input  logic [ACC_W*DIM_SIGMA-1:0]   c,
    output logic [ACC_W*DIM_SIGMA-1:0]   d
);

    // One multiply-accumulate per lane, all sharing the same weight.
    always_comb begin
        d = '0;
        for (int i = 0; i < DIM_SIGMA; i++) begin
            d[ACC_W*i +: ACC_W] = c[ACC_W*i +: ACC_W]
                                + mul_wide(a, b[SIGMA_W*i +: SIGMA_W]);
        end
    end

endmodule

// File: rtl/pe_matrix_expectation_seq.sv
// Sequencing front-end for the sigma-point expectation datapath: counts
// N_SIGMA accepted (weight, sigma) pairs, owns the running-sum registers and
// presents the weighted mean through a valid/ready handshake.
module pe_matrix_expectation_seq
    import pe_matrix_expectation_seq_pkg::*;
#(
    parameter int DIM_SIGMA = 5,
    parameter int N_SIGMA   = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    pe_matrix_expectation_seq_if.slave    bus
);

    localparam int               CNT_W    = $clog2(N_SIGMA + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SIGMA - 1);

    state_t                      state_q;
    state_t                      state_d;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            cnt_d;
    logic [ACC_W*DIM_SIGMA-1:0]  sum_q;
    logic [ACC_W*DIM_SIGMA-1:0]  sum_d;
    logic [ACC_W*DIM_SIGMA-1:0]  mac_out;
    logic                        in_ready_int;
    logic                        accept;
    logic                        last_pair;
    logic                        clear_sums;

    pe_matrix_expectation_comb #(
        .DIM_SIGMA (DIM_SIGMA)
    ) u_mac (
        .a (bus.weight),
        .b (bus.sigma),
        .c (sum_q),
        .d (mac_out)
    );

    assign accept    = bus.in_valid & in_ready_int;
    assign last_pair = (cnt_q == LAST_CNT);

    // A new run starts from zero whenever start is honoured: from IDLE, as an
    // abort in ACCUM, or in DONE only if the mean is taken in the same cycle.
    assign clear_sums = bus.start &
                        ((state_q == IDLE) || (state_q == ACCUM) ||
                         ((state_q == DONE) && bus.out_ready));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; start outranks a pair arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (!bus.start && accept && last_pair) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = bus.start ? ACCUM : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the registered state only.
    always_comb begin
        in_ready_int  = (state_q == ACCUM);
        bus.in_ready  = in_ready_int;
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.mean      = sum_q;
    end

    // Sum and counter update: clear on an honoured start, accumulate on accept.
    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (clear_sums) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            sum_d = mac_out;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Running-sum and pair-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pe_matrix_expectation_seq.sv
// Directed bench for the expectation sequencer with a queue-based reference
// model checked every cycle and literal expectations for each scenario.
module tb_pe_matrix_expectation_seq;
    import pe_matrix_expectation_seq_pkg::*;

    localparam int DIM = 2;
    localparam int N   = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pe_matrix_expectation_seq_if #(.DIM_SIGMA(DIM)) bus ();

    pe_matrix_expectation_seq #(
        .DIM_SIGMA (DIM),
        .N_SIGMA   (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: accepted pairs kept in queues, mean folded on demand.
    int     mPhase;
    longint qw[$];
    longint qx0[$];
    longint qx1[$];
    longint expMean[DIM];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive all inputs for exactly one clock period (negedge to negedge).
    task automatic applyStimulus(input logic st, input logic vld, input int w,
                                 input int x0, input int x1, input logic ordy);
        bus.start     = st;
        bus.in_valid  = vld;
        bus.weight    = w;
        bus.sigma     = {x1[31:0], x0[31:0]};
        bus.out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    // Model update: phases are 0 idle, 1 collecting, 2 holding a result.
    initial begin
        mPhase = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mPhase = 0;
                qw.delete(); qx0.delete(); qx1.delete();
            end else begin
                case (mPhase)
                    0: if (bus.start) begin
                        mPhase = 1;
                        qw.delete(); qx0.delete(); qx1.delete();
                    end
                    1: if (bus.start) begin
                        qw.delete(); qx0.delete(); qx1.delete();
                    end else if (bus.in_valid) begin
                        qw.push_back(longint'($signed(bus.weight)));
                        qx0.push_back(longint'($signed(bus.sigma[31:0])));
                        qx1.push_back(longint'($signed(bus.sigma[63:32])));
                        if (qw.size() == N) begin
                            expMean[0] = 0;
                            expMean[1] = 0;
                            for (int k = 0; k < N; k++) begin
                                expMean[0] += qw[k] * qx0[k];
                                expMean[1] += qw[k] * qx1[k];
                            end
                            mPhase = 2;
                        end
                    end
                    default: if (bus.out_ready) begin
                        if (bus.start) begin
                            mPhase = 1;
                            qw.delete(); qx0.delete(); qx1.delete();
                        end else begin
                            mPhase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            checkOutput("model in_ready", 64'(bus.in_ready), 64'(mPhase == 1));
            checkOutput("model out_valid", 64'(bus.out_valid), 64'(mPhase == 2));
            checkOutput("model busy", 64'(bus.busy), 64'(mPhase != 0));
            if (mPhase == 2) begin
                checkOutput("model mean0", bus.mean[63:0], expMean[0]);
                checkOutput("model mean1", bus.mean[127:64], expMean[1]);
            end
        end
    end

    // Standard three-pair run giving [7,16], with optional gaps and backpressure.
    task automatic runBasic(input int gap, input int hold, input string tag);
        int w[3]  = '{1, 2, 3};
        int x0[3] = '{2, 4, -1};
        int x1[3] = '{3, 5, 1};
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, w[k], x0[k], x1[k], 1'b0);
            if (k < 2) repeat (gap) idleCycle();
        end
        checkOutput({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
        for (int h = 0; h < hold; h++) begin
            checkOutput({tag, " in_ready in DONE"}, 64'(bus.in_ready), 64'd0);
            idleCycle();
        end
        checkOutput({tag, " mean0"}, bus.mean[63:0], 64'd7);
        checkOutput({tag, " mean1"}, bus.mean[127:64], 64'd16);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1);
        checkOutput({tag, " busy after accept"}, 64'(bus.busy), 64'd0);
        checkOutput({tag, " out_valid after accept"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
        checkOutput({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, " busy"}, 64'(bus.busy), 64'd0);
        checkOutput({tag, " mean0"}, bus.mean[63:0], 64'd0);
        checkOutput({tag, " mean1"}, bus.mean[127:64], 64'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.weight    = '0;
        bus.sigma     = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        idleCycle();

        // Back-to-back pairs: out_valid appears 4 cycles after start.
        runBasic(0, 0, "basic");

        // Gaps between pairs and 5 cycles of backpressure in DONE.
        runBasic(2, 5, "gaps");

        // Abort mid-run; pair on the restart cycle must be discarded.
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 5, 9, 9, 1'b0);
        applyStimulus(1'b0, 1'b1, 5, 9, 9, 1'b0);
        applyStimulus(1'b1, 1'b1, 100, 100, 100, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1, 1, 1, 1'b0);
        checkOutput("abort out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("abort mean0", bus.mean[63:0], 64'd3);
        checkOutput("abort mean1", bus.mean[127:64], 64'd3);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1);

        // Pairs offered while idle are never taken.
        applyStimulus(1'b0, 1'b1, 7, 7, 7, 1'b0);
        applyStimulus(1'b0, 1'b1, 7, 7, 7, 1'b0);
        checkOutput("idle in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("idle busy", 64'(bus.busy), 64'd0);

        // Wrap-around of 3*(2^31-1)^2 in 64 bits.
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        checkOutput("wrap mean0", bus.mean[63:0], 64'hBFFF_FFFD_0000_0003);
        checkOutput("wrap mean1", bus.mean[127:64], 64'hBFFF_FFFD_0000_0003);

        // Accept and restart in the same cycle; new run must not see old sums.
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b1);
        checkOutput("restart in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("restart out_valid", 64'(bus.out_valid), 64'd0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, -1, 5, -5, 1'b0);
        checkOutput("negative mean0", bus.mean[63:0], 64'hFFFF_FFFF_FFFF_FFF1);
        checkOutput("negative mean1", bus.mean[127:64], 64'd15);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1);

        // Reset while accumulating: outputs drop immediately.
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1, 2, 3, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkAllZero("reset in ACCUM");
        @(negedge clk);
        rst = 1'b0;
        idleCycle();
        runBasic(0, 0, "after reset ACCUM");

        // Reset while holding a result.
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 2, 3, 4, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkAllZero("reset in DONE");
        @(negedge clk);
        rst = 1'b0;
        idleCycle();
        runBasic(0, 1, "after reset DONE");

        repeat (2) idleCycle();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
